mod16_timer_arbiter: RTL and testbench

Shares one 4-bit mod-16 interval counter between NREQ requesters. Each requester asks for a delay of dur+1 counter ticks. The block grants the counter round-robin, runs it from 0 up to the requested terminal value, then pulses done to the owner. It sits above the mod-16 counter datapath as its sequencer and arbiter.

---
 rtl/mod16_timer_arbiter.sv | 133 +++++++++++++
 tb/tb_mod16_timer_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod16_timer_arbiter.sv
// Round-robin arbiter sharing one mod-16 interval counter between NREQ requesters.
// The owner's counter runs 0..dur, then a one-cycle done pulse is sent back to it.
module mod16_timer_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dur,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      cnt
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    owner_q;
    logic [WIDTH-1:0] dur_l_q;
    logic [WIDTH-1:0] cnt_q;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_q;
    logic             busy_q;

    logic             hi_found;
    logic             lo_found;
    logic [PW-1:0]    hi_idx;
    logic [PW-1:0]    lo_idx;
    logic [PW-1:0]    win_idx_d;
    logic [NREQ-1:0]  win_oh_d;
    logic [WIDTH-1:0] win_dur_d;
    logic [NREQ-1:0]  owner_oh_d;
    logic [PW-1:0]    ptr_d;

    // Rotating priority: lowest set bit at or above ptr wins, else lowest set bit overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!hi_found && req[i] && (i >= 32'(ptr_q))) begin
                hi_found = 1'b1;
                hi_idx   = PW'(i);
            end
            if (!lo_found && req[i]) begin
                lo_found = 1'b1;
                lo_idx   = PW'(i);
            end
        end
        win_idx_d = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        win_oh_d   = '0;
        win_dur_d  = '0;
        owner_oh_d = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (PW'(i) == win_idx_d) begin
                win_oh_d[i] = 1'b1;
                win_dur_d   = dur[i*WIDTH +: WIDTH];
            end
            if (PW'(i) == owner_q) begin
                owner_oh_d[i] = 1'b1;
            end
        end
        ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            dur_l_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        owner_q <= win_idx_d;
                        dur_l_q <= win_dur_d;
                        cnt_q   <= '0;
                        gnt_q   <= win_oh_d;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q == dur_l_q) begin
                        done_q  <= owner_oh_d;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_mod16_timer_arbiter.sv
// Bench for mod16_timer_arbiter: fixed vectors, hand-built corner sequences and a
// randomized run, all checked against a timeline model of each grant.
module tb_mod16_timer_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dur;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      cnt;

    mod16_timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dur  (dur),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .cnt  (cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a grant is a timeline t = 0..dur+1 edges after it was issued.
    bit m_act   = 1'b0;
    int m_owner = 0;
    int m_dur   = 0;
    int m_t     = 0;
    int m_ptr   = 0;
    bit inv_on  = 1'b0;

    task automatic model_step();
        if (rst) begin
            m_act = 1'b0; m_ptr = 0; m_t = 0; m_owner = 0; m_dur = 0;
        end else if (!m_act) begin
            if (req != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NREQ;
                    if (req[idx]) begin
                        m_owner = idx;
                        break;
                    end
                end
                m_dur = int'((dur >> (m_owner * WIDTH)) & 16'hF);
                m_t   = 0;
                m_act = 1'b1;
            end
        end else if (m_t == m_dur + 1) begin
            m_act = 1'b0;
            m_ptr = (m_owner + 1) % NREQ;
        end else begin
            m_t++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_check(input string tag);
        logic [31:0] eg, ed, ec;
        @(posedge clk);
        model_step();
        #1;
        eg = m_act ? (32'd1 << m_owner) : 32'd0;
        ed = (m_act && m_t == m_dur + 1) ? (32'd1 << m_owner) : 32'd0;
        ec = m_act ? 32'((m_t > m_dur) ? m_dur : m_t) : 32'd0;
        check({tag, ".gnt"},  32'(gnt),  eg);
        check({tag, ".done"}, 32'(done), ed);
        check({tag, ".busy"}, 32'(busy), 32'(m_act));
        check({tag, ".cnt"},  32'(cnt),  ec);
    endtask

    always @(negedge clk) begin
        if (inv_on && !rst) begin
            check("inv.gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
            check("inv.done_in_gnt", 32'(done & ~gnt), 32'd0);
            check("inv.busy_eq_gnt", 32'(busy), 32'(|gnt));
            if (busy) check("inv.cnt_le_dur", 32'(int'(cnt) <= m_dur), 32'd1);
        end
    end

    typedef struct {
        logic                  rst;
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] dur;
        logic [NREQ-1:0]       gnt;
        logic [NREQ-1:0]       done;
        logic                  busy;
        logic [WIDTH-1:0]      cnt;
    } vec_t;

    vec_t tbl[$];
    logic [NREQ-1:0] gq[$];

    initial begin
        int starts[$];
        int lens[$];
        int owners[$];
        int glen, maxc, dcnt, dcnt_val, i;
        bit wrapped;

        // rst, req, dur -> gnt, done, busy, cnt (after the edge)
        tbl.push_back('{1'b1, 4'hF, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0});
        tbl.push_back('{1'b1, 4'hF, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 16'h0000, 4'h1, 4'h0, 1'b1, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 16'h0000, 4'h1, 4'h1, 1'b1, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 16'h0000, 4'h2, 4'h0, 1'b1, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 16'h0000, 4'h2, 4'h2, 1'b1, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0});
        tbl.push_back('{1'b1, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'h4, 16'h0500, 4'h4, 4'h0, 1'b1, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 4'h1});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 4'h2});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 4'h3});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 4'h4});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 4'h4, 4'h0, 1'b1, 4'h5});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 4'h4, 4'h4, 1'b1, 4'h5});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 4'h0, 4'h0, 1'b0, 4'h0});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 4'h0, 4'h0, 1'b0, 4'h0});

        rst = 1'b1; req = '0; dur = '0;
        foreach (tbl[n]) begin
            rst = tbl[n].rst; req = tbl[n].req; dur = tbl[n].dur;
            @(posedge clk);
            model_step();
            #1;
            inv_on = 1'b1;
            check($sformatf("vec%0d.gnt", n),  32'(gnt),  32'(tbl[n].gnt));
            check($sformatf("vec%0d.done", n), 32'(done), 32'(tbl[n].done));
            check($sformatf("vec%0d.busy", n), 32'(busy), 32'(tbl[n].busy));
            check($sformatf("vec%0d.cnt", n),  32'(cnt),  32'(tbl[n].cnt));
        end

        // dur=15: counter must reach 15 without wrapping, grant lasts 17 cycles
        rst = 1'b1; step_check("d15.rst");
        rst = 1'b0; req = 4'h1; dur = 16'h000F;
        glen = 0; maxc = 0; wrapped = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step_check("d15");
            req = '0;
            if (gnt != '0) begin
                if (glen > 0 && int'(cnt) < maxc) wrapped = 1'b1;
                glen++;
                if (int'(cnt) > maxc) maxc = int'(cnt);
            end
        end
        check("d15.len", 32'(glen), 32'd17);
        check("d15.maxcnt", 32'(maxc), 32'd15);
        check("d15.nowrap", 32'(wrapped), 32'd0);

        // Round-robin with all requesters held, dur=1 each
        rst = 1'b1; step_check("rr.rst");
        rst = 1'b0; req = 4'hF; dur = 16'h1111;
        gq.delete();
        for (int c = 0; c < 22; c++) begin
            step_check("rr");
            gq.push_back(gnt);
        end
        i = 0;
        while (i < gq.size()) begin
            if (gq[i] != '0) begin
                int s;
                s = i;
                while (i < gq.size() && gq[i] == gq[s]) i++;
                if (i < gq.size()) begin
                    starts.push_back(s);
                    lens.push_back(i - s);
                    owners.push_back($clog2(gq[s]));
                end
            end else begin
                i++;
            end
        end
        check("rr.count", 32'(owners.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < owners.size(); k++) begin
            check($sformatf("rr.owner%0d", k), 32'(owners[k]), 32'(k % NREQ));
            check($sformatf("rr.len%0d", k), 32'(lens[k]), 32'd3);
            if (k > 0) check($sformatf("rr.spacing%0d", k), 32'(starts[k] - starts[k-1]), 32'd4);
        end

        // Drop req and change dur mid-run: run still finishes at the latched terminal value
        rst = 1'b1; step_check("mid.rst");
        rst = 1'b0; req = 4'h2; dur = 16'h0060;
        step_check("mid.grant");
        check("mid.gnt1", 32'(gnt), 32'h2);
        req = '0; dur = 16'h0020;
        dcnt = 0; dcnt_val = -1;
        for (int c = 0; c < 12; c++) begin
            step_check("mid");
            if (done != '0) begin
                dcnt++;
                dcnt_val = int'(cnt);
                check("mid.done_owner", 32'(done), 32'h2);
            end
        end
        check("mid.done_count", 32'(dcnt), 32'd1);
        check("mid.done_cnt", 32'(dcnt_val), 32'd6);

        // Reset during the 4th cycle of a run: silent abort, pointer back to 0
        rst = 1'b1; step_check("abort.rst0");
        rst = 1'b0; req = 4'h2; dur = 16'h0060;
        step_check("abort.grant");
        req = '0;
        for (int c = 0; c < 3; c++) step_check("abort.run");
        check("abort.cnt_before", 32'(cnt), 32'd3);
        rst = 1'b1;
        step_check("abort.rst");
        check("abort.gnt", 32'(gnt), 32'd0);
        check("abort.cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            step_check("abort.idle");
            if (done != '0) dcnt++;
        end
        check("abort.nodone", 32'(dcnt), 32'd0);
        req = 4'hF; dur = '0;
        step_check("abort.regrant");
        check("abort.ptr0", 32'(gnt), 32'h1);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            req = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            dur = (NREQ*WIDTH)'($urandom);
            step_check("rand");
        end

        inv_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
